// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional: define MULDIV_FAST_MULT_EN for a single-cycle combinational MULT/MULTU.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] ALU_A,
  input  logic [WIDTH-1:0] ALU_B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // Handshake: Start is sampled only while state==IDLE (Busy=0); Done pulses
  // for exactly one cycle on the edge HI/LO take an arithmetic result.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
  state_t state;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_mag;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_lo, neg_hi, div0;

  logic             arith_op, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign arith_op  = ~MDOp[2];
  assign signed_op = ~MDOp[2] & ~MDOp[0];
  assign a_neg     = signed_op & ALU_A[WIDTH-1];
  assign b_neg     = signed_op & ALU_B[WIDTH-1];
  assign a_mag_in  = a_neg ? (~ALU_A + 1'b1) : ALU_A;
  assign b_mag_in  = b_neg ? (~ALU_B + 1'b1) : ALU_B;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, a_mag_in} * {{WIDTH{1'b0}}, b_mag_in};
  assign fast_prod = (a_neg ^ b_neg) ? (~fast_mag + 1'b1) : fast_mag;
`endif

  // One iteration: multiply shifts right with add into the upper half;
  // divide shifts {rem,quot} left and restores when the trial subtract borrows.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_mag};
    acc_step  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_diff[WIDTH]) acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_lo ? (~acc + 1'b1) : acc;
    rem_fix  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    quot_fix = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    if (div0) quot_fix = {WIDTH{1'b1}};
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      acc    <= '0;
      b_mag  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (arith_op) begin
`ifdef MULDIV_FAST_MULT_EN
              if (!MDOp[1]) begin
                HI   <= fast_prod[2*WIDTH-1:WIDTH];
                LO   <= fast_prod[WIDTH-1:0];
                Done <= 1'b1;
              end else begin
`else
              begin
`endif
                state  <= CALC;
                Busy   <= 1'b1;
                acc    <= {{WIDTH{1'b0}}, a_mag_in};
                b_mag  <= b_mag_in;
                cnt    <= '0;
                is_div <= MDOp[1];
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                div0   <= MDOp[1] & (ALU_B == '0);
              end
            end else if (MDOp == 3'd4) begin
              HI <= ALU_A;
            end else if (MDOp == 3'd5) begin
              LO <= ALU_A;
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            HI <= rem_fix;
            LO <= quot_fix;
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] ALU_A = '0;
  logic [31:0] ALU_B = '0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MDOp(MDOp),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  // Reference: {HI,LO} from the architectural definition of each op.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] q, r;
    logic [63:0] up;
    case (op)
      3'd0: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycles from the Start cycle to the Done cycle, inclusive.
  function automatic int exp_lat(input logic [2:0] op);
`ifdef MULDIV_FAST_MULT_EN
    if (op < 3'd2) return 1;
`endif
    return 34;
  endfunction

  // Issue one arithmetic op and wait (bounded) for Done; sampling on negedges.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit on_done, output logic [63:0] got, output int lat,
                       output int busy_n, output bit timeout);
    if (!on_done) @(negedge CLK);
    MDOp = op; ALU_A = a; ALU_B = b; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    lat = 1;
    busy_n = (Busy === 1'b1) ? 1 : 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(negedge CLK);
      lat++;
      if (Busy === 1'b1) busy_n++;
    end
    timeout = (Done !== 1'b1);
    got = {HI, LO};
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", LO); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
    Reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops[6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2};
    logic [31:0] as[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h64, 32'h64};
    logic [31:0] bs[6]  = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [63:0] want[6] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFD,
                             64'h00000000_80000000, 64'h00000064_FFFFFFFF, 64'h00000064_FFFFFFFF};
    logic [63:0] got;
    int lat, busy_n;
    bit to;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, got, lat, busy_n, to);
      checks++; if (to) begin errors++; $display("FAIL directed%0d_timeout no Done within %0d cycles", i, lat); end
      checks++; if (got !== want[i]) begin errors++; $display("FAIL directed%0d_result got %h exp %h", i, got, want[i]); end
      checks++; if (lat != exp_lat(ops[i])) begin errors++; $display("FAIL directed%0d_latency got %0d exp %0d", i, lat, exp_lat(ops[i])); end
      checks++; if (busy_n != exp_lat(ops[i]) - 1) begin errors++; $display("FAIL directed%0d_busy got %0d exp %0d", i, busy_n, exp_lat(ops[i]) - 1); end
      @(negedge CLK);
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL directed%0d_done_pulse got %b exp 0", i, Done); end
    end
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] got, exp;
    int lat, busy_n;
    bit to;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      exp_q.push_back(ref_result(op, a, b));
      do_op(op, a, b, 1'b0, got, lat, busy_n, to);
      exp = exp_q.pop_front();
      checks++; if (to || got !== exp) begin errors++; $display("FAIL random%0d op%0d a=%h b=%h got %h exp %h", i, op, a, b, got, exp); end
      checks++; if (lat != exp_lat(op)) begin errors++; $display("FAIL random%0d_latency got %0d exp %0d", i, lat, exp_lat(op)); end
    end
  endtask

  task automatic test_move;
    @(negedge CLK); MDOp = 3'd4; ALU_A = 32'h1234; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mthi got %h exp 00001234", HI); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b exp 0", Done); end
    MDOp = 3'd5; ALU_A = 32'h5678; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    checks++; if (LO !== 32'h5678) begin errors++; $display("FAIL mtlo got %h exp 00005678", LO); end
    MDOp = 3'd6; ALU_A = 32'hAAAA; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    checks++; if ({HI, LO} !== 64'h00001234_00005678) begin errors++; $display("FAIL reserved_op got %h exp 0000123400005678", {HI, LO}); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reserved_busy got %b exp 0", Busy); end
  endtask

  task automatic test_busy_ignore;
    int n;
    @(negedge CLK); MDOp = 3'd3; ALU_A = 32'd1000; ALU_B = 32'd7; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    repeat (5) @(negedge CLK);
    MDOp = 3'd5; ALU_A = 32'hDEAD; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy_mid got %b exp 1", Busy); end
    checks++; if ({HI, LO} !== 64'h00001234_00005678) begin errors++; $display("FAIL busy_hold got %h exp 0000123400005678", {HI, LO}); end
    n = 0;
    while (Done !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    checks++; if ({HI, LO} !== {32'd6, 32'd142} || Done !== 1'b1) begin errors++; $display("FAIL busy_ignore_result got %h done %b exp 000000060000008e", {HI, LO}, Done); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] got;
    int lat, busy_n;
    bit to;
    do_op(3'd3, 32'd100, 32'd7, 1'b0, got, lat, busy_n, to);
    checks++; if (to || got !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_first got %h exp 000000020000000e", got); end
    do_op(3'd1, 32'd3, 32'd4, 1'b1, got, lat, busy_n, to);
    checks++; if (to || got !== 64'd12) begin errors++; $display("FAIL b2b_second got %h exp 000000000000000c", got); end
    checks++; if (lat != exp_lat(3'd1)) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, exp_lat(3'd1)); end
  endtask

  task automatic test_reset_mid_op;
    logic [63:0] got;
    int lat, busy_n;
    bit to;
    @(negedge CLK); MDOp = 3'd4; ALU_A = 32'hBEEF; Start = 1'b1;
    @(negedge CLK); MDOp = 3'd2; ALU_A = 32'd999; ALU_B = 32'd3;
    @(negedge CLK); Start = 1'b0;
    repeat (9) @(negedge CLK);
    Reset = 1'b1;
    #1;
    checks++; if ({HI, LO} !== 64'd0) begin errors++; $display("FAIL midreset_hilo got %h exp 0", {HI, LO}); end
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midreset_flags busy %b done %b exp 0 0", Busy, Done); end
    @(negedge CLK); Reset = 1'b0;
    do_op(3'd0, 32'd6, 32'd7, 1'b0, got, lat, busy_n, to);
    checks++; if (to || got !== 64'd42) begin errors++; $display("FAIL midreset_mult got %h exp 000000000000002a", got); end
    checks++; if (lat != exp_lat(3'd0) || busy_n != exp_lat(3'd0) - 1) begin errors++; $display("FAIL midreset_timing lat %0d busy %0d exp %0d %0d", lat, busy_n, exp_lat(3'd0), exp_lat(3'd0) - 1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_move();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
